// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and width defaults for the memory-access stage
package mem_stage_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int RD_W_DEF   = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [RD_W_DEF-1:0]   rd;
        logic [DATA_W_DEF-1:0] data;
    } wb_rec_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// rtl/mem_timeout_counter.sv - ACCESS-cycle counter that flags expiry after LIMIT cycles
module mem_timeout_counter #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    // expire marks the last allowed cycle; the owner decides whether an ack beats it
    assign expire = en && (count == CW'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && !expire) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage; MEM_TIMEOUT_EN adds an ACCESS timeout with fault pulse
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int RD_W           = RD_W_DEF,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic [RD_W-1:0]   rd,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              reg_write,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              fault
);

    state_t          state;
    logic [RD_W-1:0] lat_rd;
    logic            lat_we;
    logic            timeout_expire;

    assign in_ready = (state == IDLE);

`ifdef MEM_TIMEOUT_EN
    mem_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == IDLE),
        .en     (state == ACCESS),
        .expire (timeout_expire)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_rd     <= '0;
            lat_we     <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            fault      <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            fault    <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (mem_write || mem_read) begin
                            // stores win over loads; a store never writes the register file
                            state      <= ACCESS;
                            dmem_req   <= 1'b1;
                            dmem_we    <= mem_write;
                            dmem_addr  <= alu_result;
                            dmem_wdata <= mem_write ? store_data : '0;
                            lat_rd     <= rd;
                            lat_we     <= reg_write && !mem_write;
                        end else begin
                            wb_valid <= 1'b1;
                            wb_we    <= reg_write;
                            wb_rd    <= rd;
                            wb_data  <= alu_result;
                        end
                    end
                end
                ACCESS: begin
                    // dmem_we still identifies a store here since it is held for the whole access
                    if (dmem_ack) begin
                        state    <= IDLE;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_we    <= lat_we;
                        wb_rd    <= lat_rd;
                        wb_data  <= dmem_we ? '0 : dmem_rdata;
                    end else if (timeout_expire) begin
                        state    <= IDLE;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        fault    <= 1'b1;
                        wb_valid <= 1'b1;
                        wb_we    <= 1'b0;
                        wb_rd    <= lat_rd;
                        wb_data  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 16-bit RISC pipeline, directly downstream of the ALU. It accepts the ALU result plus control from execute. For loads and stores it runs a request/acknowledge transaction on the data-memory port, using the ALU result as the address. It then presents one registered writeback record (data, destination register, write enable) to the register file. ALU-only instructions pass through with one cycle of latency; memory instructions stall execute until the memory acknowledges.

## Interface
Parameters:
- DATA_W, 16, datapath and memory word width
- RD_W, 3, destination register index width
- TIMEOUT_CYCLES, 15, cycles in ACCESS before abort (used only with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  execute presents an instruction
- in_ready  out  1  stage can accept; high only in IDLE
- alu_result  in  DATA_W  ALU output; address for load/store, writeback value otherwise
- store_data  in  DATA_W  rs2 value for stores
- rd  in  RD_W  destination register
- mem_read, mem_write, reg_write  in  1 each  decoded control
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  1 = write
- dmem_addr  out  DATA_W  word address
- dmem_wdata  out  DATA_W  store data
- dmem_rdata  in  DATA_W  load data, valid with ack
- dmem_ack  in  1  one-cycle completion pulse
- wb_valid  out  1  one-cycle writeback/retire pulse
- wb_we  out  1  register-file write enable (qualified by wb_valid)
- wb_rd  out  RD_W  destination register
- wb_data  out  DATA_W  writeback value
- fault  out  1  one-cycle pulse on memory timeout (MEM_TIMEOUT_EN only, else tied 0)

## Operation
- States:
  - IDLE: in_ready=1.
  - ACCESS: in_ready=0, dmem_req=1.
- Accept: an instruction is accepted when in_valid && in_ready. rd and reg_write are latched on accept.
- Non-memory instruction accepted in IDLE:
  - Next cycle: wb_valid=1, wb_data=alu_result, wb_we=reg_write.
  - State stays IDLE, so back-to-back accepts are allowed.
- Load (mem_read=1, mem_write=0):
  - IDLE→ACCESS. dmem_addr=alu_result, dmem_we=0, registered.
  - On dmem_ack: capture dmem_rdata, go to IDLE.
  - Next cycle: wb_valid=1, wb_data=captured rdata, wb_we=reg_write.
- Store (mem_write=1):
  - IDLE→ACCESS. dmem_we=1, dmem_wdata=store_data.
  - On ack: go to IDLE.
  - Next cycle: wb_valid=1, wb_we=0, wb_data=0.
  - mem_read is ignored when mem_write=1; store takes priority.
- ACCESS hold rule: dmem_addr, dmem_we and dmem_wdata are stable for the whole time dmem_req is high.
- dmem_ack outside ACCESS is ignored.
- wb_valid has no backpressure; the register file always accepts.

## Timing
- Reset (asynchronous, on rst_n low): state=IDLE, in_ready=1, and every other output is 0 (dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, wb_we, wb_rd, wb_data, fault).
- Reset during ACCESS: dmem_req drops immediately and the transaction is abandoned. No wb_valid is produced for it.
- ALU-only latency: 1 cycle from accept to wb_valid. Throughput is 1 per cycle.
- Memory latency:
  - dmem_req rises 1 cycle after accept.
  - wb_valid follows 1 cycle after the dmem_ack cycle.
  - With ack arriving N cycles after req rises, latency is N+2 cycles (N≥0 means ack in the first ACCESS cycle).
- in_ready falls in the cycle after a memory accept. It rises in the cycle after ack, so a new accept can coincide with that instruction's wb_valid.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A counter runs in ACCESS and clears on entry.
  - If TIMEOUT_CYCLES cycles elapse without ack: drop dmem_req, pulse fault=1 and wb_valid=1 with wb_we=0, return to IDLE.
  - An ack in the same cycle the counter expires wins: normal completion, no fault.
- MEM_TIMEOUT_EN undefined: no counter is built, fault is tied 0, and ACCESS waits indefinitely.

## Structure
- Shared package mem_stage_pkg holds:
  - state enum {IDLE, ACCESS}
  - DATA_W and RD_W defaults
  - writeback record typedef (valid, we, rd, data)
- Sub-module mem_timeout_counter: load/clear, enable, expire output. Instantiated only under MEM_TIMEOUT_EN.

## Test plan
- ALU passthrough: accept alu_result=0x1234, rd=3, reg_write=1 → next cycle wb_valid=1, wb_data=0x1234, wb_rd=3, wb_we=1. Three back-to-back ALU-only ops → three consecutive wb_valid pulses.
- Load: alu_result=0x0040, mem_read=1, rd=5; ack 2 cycles after req with rdata=0xBEEF → dmem_we=0 and addr=0x0040 held throughout; wb_data=0xBEEF, wb_rd=5; latency 4 cycles; in_ready=0 during ACCESS.
- Store: alu_result=0x0010, store_data=0xA5A5, mem_write=1, mem_read=1 → dmem_we=1, wdata=0xA5A5; after ack, wb_valid=1 with wb_we=0.
- Reset mid-access: assert rst_n=0 while dmem_req=1 → dmem_req=0 immediately, all outputs 0; after release, in_ready=1 and no stray wb_valid.
- Timeout (MEM_TIMEOUT_EN, TIMEOUT_CYCLES=15): never ack → fault pulses exactly once, 15 cycles after req rises, dmem_req=0, wb_we=0. Ack on cycle 15 → no fault, normal writeback.
